divider: RTL and testbench

Sequential unsigned N-bit integer divider for the scalar ALU, the inverse operation to the combinational multiplier. It accepts a dividend/divisor pair on a start strobe and computes one quotient bit per clock with a restoring shift-subtract algorithm. It then presents the quotient, the remainder and ALU-style z/n/c/v flags with a one-cycle done pulse. The ALU control stalls on busy while a division is in flight.

---
 rtl/divider.sv | 164 ++++++++++++++++
 tb/tb_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// divider: sequential unsigned N-bit restoring divider for the scalar ALU.
// One quotient bit is produced per clock. A normal division takes N+2 cycles
// from acceptance to the next possible acceptance. A divide by zero takes 2.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request a division; only honoured while idle
//   a, b       dividend / divisor, sampled on an accepted start
//   result     quotient (registered, held until the next completion)
//   remainder  remainder (registered, held until the next completion)
//   busy       high from the accepted start through the done cycle
//   done       one-cycle completion pulse
//   z_flag     quotient == 0
//   n_flag     quotient MSB
//   c_flag     remainder != 0 (inexact division)
//   v_flag     divide by zero
module divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         z_flag,
  output logic         n_flag,
  output logic         c_flag,
  output logic         v_flag
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;       // dividend shifting out / quotient shifting in
  logic [N-1:0]  b_q, b_d;       // latched divisor
  logic [N-1:0]  r_q, r_d;       // partial remainder (always < divisor)
  logic [CW-1:0] cnt_q, cnt_d;   // iteration index 0..N-1
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  // One restoring step. The shifted partial remainder needs N+1 bits so the
  // compare against the divisor never overflows. After the conditional
  // subtract the value is below the divisor again, so N stored bits suffice
  // and the subtraction can be done modulo 2^N.
  logic [N:0]   r_shift;
  logic         sub_ok;
  logic [N-1:0] r_iter;
  logic [N-1:0] q_iter;

  assign r_shift = {r_q, q_q[N-1]};
  assign sub_ok  = (r_shift >= {1'b0, b_q});
  assign r_iter  = sub_ok ? (r_shift[N-1:0] - b_q) : r_shift[N-1:0];
  assign q_iter  = {q_q[N-2:0], sub_ok};

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rem_d    = rem_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (b != '0) begin
            q_d     = a;
            b_d     = b;
            r_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            // Divide by zero: no iterations, report immediately.
            result_d = '1;
            rem_d    = a;
            z_d      = 1'b0;
            n_d      = 1'b1;
            c_d      = (a != '0);
            v_d      = 1'b1;
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        q_d   = q_iter;
        r_d   = r_iter;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          result_d = q_iter;
          rem_d    = r_iter;
          z_d      = (q_iter == '0);
          n_d      = q_iter[N-1];
          c_d      = (r_iter != '0);
          v_d      = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      q_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end

  // busy/done decode straight from the state register, so they are glitch-free
  // and drop to zero the instant reset is asserted.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign remainder = rem_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;
  assign c_flag    = c_q;
  assign v_flag    = v_q;

endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for divider. A timing model observes start at
// each rising edge, decides acceptance from the documented cycle counts, and
// pushes the expected result (plain / and %) into a queue. A monitor on the
// falling edge pops and compares whenever done is seen or expected, and checks
// busy, done and the held outputs every cycle.
module tb_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic [N-1:0] result, remainder;
  logic         busy, done, z_flag, n_flag, c_flag, v_flag;

  divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .result(result), .remainder(remainder), .busy(busy), .done(done),
    .z_flag(z_flag), .n_flag(n_flag), .c_flag(c_flag), .v_flag(v_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] op_a, op_b, q, r;
    logic         z, n, c, v;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;          // index of the most recent rising edge
  bit          act_valid = 1'b0; // an operation has been accepted since reset
  int unsigned act_done = 0;     // edge after which done is expected
  logic [N-1:0] held_q = '0, held_r = '0;
  logic         held_z = 1'b0, held_n = 1'b0, held_c = 1'b0, held_v = 1'b0;
  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0b expected %0b (edge %0d)", name, act, expv, cyc);
  endtask

  function automatic exp_t ref_div(input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    e.op_a = x;
    e.op_b = y;
    if (y == 0) begin
      e.q = '1;
      e.r = x;
      e.v = 1'b1;
    end else begin
      e.q = x / y;
      e.r = x % y;
      e.v = 1'b0;
    end
    e.z = (e.q == 0);
    e.n = e.q[N-1];
    e.c = (e.r != 0);
    return e;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    act_valid = 1'b0;
    held_q = '0; held_r = '0;
    held_z = 1'b0; held_n = 1'b0; held_c = 1'b0; held_v = 1'b0;
  endtask

  // Acceptance model: idle again two edges after the done edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      clear_model();
    end else if (start && (!act_valid || cyc >= act_done + 2)) begin
      exp_q.push_back(ref_div(a, b));
      act_valid = 1'b1;
      act_done  = (b == 0) ? cyc : cyc + N;
    end
  end

  always @(posedge rst) clear_model();

  // Monitor
  always @(negedge clk) begin
    bit   done_exp, busy_exp;
    exp_t e;
    done_exp = act_valid && (cyc == act_done);
    busy_exp = act_valid && (cyc <= act_done);
    chk1("done", done, done_exp);
    chk1("busy", busy, busy_exp);
    if (done === 1'b1 || done_exp) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected no pending division (edge %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        held_q = e.q; held_r = e.r;
        held_z = e.z; held_n = e.n; held_c = e.c; held_v = e.v;
        $display("txn edge %0d: 0x%0h / 0x%0h -> q=0x%0h r=0x%0h (dut q=0x%0h r=0x%0h v=%0b)",
                 cyc, e.op_a, e.op_b, e.q, e.r, result, remainder, v_flag);
      end
    end
    chk("result", result, held_q);
    chk("remainder", remainder, held_r);
    chk1("z_flag", z_flag, held_z);
    chk1("n_flag", n_flag, held_n);
    chk1("c_flag", c_flag, held_c);
    chk1("v_flag", v_flag, held_v);
  end

  // Called at a falling edge; returns at the falling edge before the first
  // rising edge at which the model says a start will be accepted.
  task automatic wait_idle();
    int g = 0;
    while (act_valid && (cyc + 1 < act_done + 2) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      total++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", g);
    end
  endtask

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, output int unsigned k);
    wait_idle();
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  initial begin
    int unsigned k;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(32'd100, 32'd7, k);
    issue(32'd0, 32'd5, k);
    issue(32'hFFFF_FFFF, 32'd1, k);
    issue(32'd42, 32'd0, k);
    issue(32'd10, 32'd3, k);

    // Requests during RUN and DONE are ignored; operands change mid-run.
    issue(32'd1000, 32'd10, k);
    while (cyc < k + 5) @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    while (cyc < k + N) @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a division.
    issue(32'd77, 32'd5, k);
    while (cyc < k + 10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_remainder", remainder, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(32'd77, 32'd5, k);

    // start tied high: back-to-back divisions.
    wait_idle();
    a = 32'hFFFF_FFFF; b = 32'h0001_0000; start = 1'b1;
    repeat (4 * (N + 2)) @(negedge clk);
    start = 1'b0;

    // Randomized operands with start held high, including divide by zero.
    wait_idle();
    start = 1'b1;
    repeat (20 * (N + 2)) begin
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 50)) : 32'($urandom);
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'($urandom) >> $urandom_range(0, 31);
        default: b = 32'($urandom);
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL pending_at_end: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
